// File: rtl/ray_bounce_ctrl.sv
// rtl/ray_bounce_ctrl.sv - per-pixel intersect/reflect path sequencer
// Owns the current ray state and hands it to the intersector and reflector in turn.
package ray_bounce_pkg;
   typedef struct packed {
      logic [23:0] reflectance;
      logic [23:0] emission;
      logic [7:0]  kind;
   } material;
endpackage

module ray_bounce_ctrl
   import ray_bounce_pkg::*;
#(
   parameter int          MAX_BOUNCES  = 4,
   parameter int          RFLX_TIMEOUT = 63,
   parameter logic [23:0] FP24_ONE     = 24'h3F0000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ray_valid,
   output logic          ray_ready,
   input  logic [71:0]   ray_origin,
   input  logic [71:0]   ray_dir,
   output logic          isect_start,
   output logic [71:0]   isect_origin,
   output logic [71:0]   isect_dir,
   input  logic          isect_done,
   input  logic          isect_hit,
   input  logic [71:0]   isect_pos,
   input  logic [71:0]   isect_normal,
   input  material       isect_mat,
   output logic          rflx_hit_valid,
   output logic [71:0]   rflx_ray_dir,
   output logic [71:0]   rflx_ray_color,
   output logic [71:0]   rflx_income_light,
   output logic [71:0]   rflx_hit_pos,
   output logic [71:0]   rflx_hit_normal,
   output material       rflx_hit_mat,
   input  logic [71:0]   rflx_new_dir,
   input  logic [71:0]   rflx_new_origin,
   input  logic [71:0]   rflx_new_color,
   input  logic [71:0]   rflx_new_income_light,
   input  logic          rflx_done,
   output logic [71:0]   pix_color,
   output logic          pix_valid,
   input  logic          pix_ready,
   output logic          pix_err
);
   localparam int            CW         = $clog2(RFLX_TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_LAST  = CW'(RFLX_TIMEOUT - 1);
   localparam logic [3:0]    BOUNCE_CAP = 4'(MAX_BOUNCES);

   typedef enum logic [2:0] {
      S_IDLE, S_ISECT_REQ, S_ISECT_WAIT, S_RFLX_REQ, S_RFLX_WAIT, S_OUTPUT
   } state_t;

   state_t        state;
   logic [71:0]   color;
   logic [71:0]   light;
   logic [3:0]    bounce;
   logic [CW-1:0] wait_cnt;
   logic [3:0]    next_bounce;
   logic          black;

   // A channel whose exponent is zero carries no energy, so all three zero ends the path.
   always_comb begin
      next_bounce = bounce + 4'd1;
      black = (rflx_new_color[22:16] == 7'd0) && (rflx_new_color[46:40] == 7'd0) &&
              (rflx_new_color[70:64] == 7'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= S_IDLE;
         ray_ready         <= 1'b1;
         isect_start       <= 1'b0;
         isect_origin      <= '0;
         isect_dir         <= '0;
         rflx_hit_valid    <= 1'b0;
         rflx_ray_dir      <= '0;
         rflx_ray_color    <= '0;
         rflx_income_light <= '0;
         rflx_hit_pos      <= '0;
         rflx_hit_normal   <= '0;
         rflx_hit_mat      <= '0;
         pix_color         <= '0;
         pix_valid         <= 1'b0;
         pix_err           <= 1'b0;
         color             <= '0;
         light             <= '0;
         bounce            <= '0;
         wait_cnt          <= '0;
      end else begin
         isect_start    <= 1'b0;
         rflx_hit_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ray_valid) begin
                  isect_origin <= ray_origin;
                  isect_dir    <= ray_dir;
                  color        <= {3{FP24_ONE}};
                  light        <= '0;
                  bounce       <= '0;
                  ray_ready    <= 1'b0;
                  isect_start  <= 1'b1;
                  state        <= S_ISECT_REQ;
               end
            end
            S_ISECT_REQ: state <= S_ISECT_WAIT;
            S_ISECT_WAIT: begin
               if (isect_done) begin
                  if (isect_hit) begin
                     rflx_ray_dir      <= isect_dir;
                     rflx_ray_color    <= color;
                     rflx_income_light <= light;
                     rflx_hit_pos      <= isect_pos;
                     rflx_hit_normal   <= isect_normal;
                     rflx_hit_mat      <= isect_mat;
                     rflx_hit_valid    <= 1'b1;
                     state             <= S_RFLX_REQ;
                  end else begin
                     pix_color <= light;
                     pix_err   <= 1'b0;
                     pix_valid <= 1'b1;
                     state     <= S_OUTPUT;
                  end
               end
            end
            S_RFLX_REQ: begin
               wait_cnt <= '0;
               state    <= S_RFLX_WAIT;
            end
            S_RFLX_WAIT: begin
               if (rflx_done) begin
                  isect_dir    <= rflx_new_dir;
                  isect_origin <= rflx_new_origin;
                  color        <= rflx_new_color;
                  light        <= rflx_new_income_light;
                  bounce       <= next_bounce;
                  if (next_bounce == BOUNCE_CAP || black) begin
                     pix_color <= rflx_new_income_light;
                     pix_err   <= 1'b0;
                     pix_valid <= 1'b1;
                     state     <= S_OUTPUT;
                  end else begin
                     isect_start <= 1'b1;
                     state       <= S_ISECT_REQ;
                  end
               end else if (wait_cnt == WAIT_LAST) begin
                  pix_color <= light;
                  pix_err   <= 1'b1;
                  pix_valid <= 1'b1;
                  state     <= S_OUTPUT;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            S_OUTPUT: begin
               if (pix_ready) begin
                  pix_valid <= 1'b0;
                  pix_err   <= 1'b0;
                  ray_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ray_bounce_ctrl.sv
// tb/tb_ray_bounce_ctrl.sv - randomized path bench against a bounce-sequence reference model
module tb_ray_bounce_ctrl;
   import ray_bounce_pkg::*;

   localparam int          MAXB     = 4;
   localparam int          TMO      = 63;
   localparam logic [71:0] ONE3     = {3{24'h3F0000}};
   localparam logic [71:0] EXP_MASK = {3{24'h7F0000}};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ray_valid = 1'b0;
   logic        ray_ready;
   logic [71:0] ray_origin = '0, ray_dir = '0;
   logic        isect_start;
   logic [71:0] isect_origin, isect_dir;
   logic        isect_done = 1'b0, isect_hit = 1'b0;
   logic [71:0] isect_pos = '0, isect_normal = '0;
   material     isect_mat = '0;
   logic        rflx_hit_valid;
   logic [71:0] rflx_ray_dir, rflx_ray_color, rflx_income_light, rflx_hit_pos, rflx_hit_normal;
   material     rflx_hit_mat;
   logic [71:0] rflx_new_dir = '0, rflx_new_origin = '0, rflx_new_color = '0, rflx_new_income_light = '0;
   logic        rflx_done = 1'b0;
   logic [71:0] pix_color;
   logic        pix_valid;
   logic        pix_ready = 1'b0;
   logic        pix_err;

   ray_bounce_ctrl #(.MAX_BOUNCES(MAXB), .RFLX_TIMEOUT(TMO), .FP24_ONE(24'h3F0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_origin(ray_origin), .ray_dir(ray_dir),
      .isect_start(isect_start), .isect_origin(isect_origin), .isect_dir(isect_dir),
      .isect_done(isect_done), .isect_hit(isect_hit), .isect_pos(isect_pos),
      .isect_normal(isect_normal), .isect_mat(isect_mat),
      .rflx_hit_valid(rflx_hit_valid), .rflx_ray_dir(rflx_ray_dir), .rflx_ray_color(rflx_ray_color),
      .rflx_income_light(rflx_income_light), .rflx_hit_pos(rflx_hit_pos),
      .rflx_hit_normal(rflx_hit_normal), .rflx_hit_mat(rflx_hit_mat),
      .rflx_new_dir(rflx_new_dir), .rflx_new_origin(rflx_new_origin), .rflx_new_color(rflx_new_color),
      .rflx_new_income_light(rflx_new_income_light), .rflx_done(rflx_done),
      .pix_color(pix_color), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_err(pix_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int n_start = 0;
   int n_pulse = 0;
   always @(negedge clk) begin
      if (isect_start) n_start++;
      if (rflx_hit_valid) n_pulse++;
   end

   // One path scenario: what the intersector and reflector will answer on each bounce.
   logic        p_hit  [16];
   logic [71:0] p_ncol [16], p_nlit [16], p_ndir [16], p_norg [16], p_pos [16], p_nrm [16];
   material     p_mat  [16];
   int          p_rlat [16];
   int          p_ilat, p_stall, p_reset, p_hold;
   logic [71:0] p_ro, p_rd;

   function automatic logic [71:0] rnd72();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[71:0];
   endfunction

   task automatic gen_path();
      logic [63:0] m;
      p_ro = rnd72(); p_rd = rnd72();
      p_ilat = $urandom_range(0, 4); p_stall = -1; p_reset = -1; p_hold = $urandom_range(0, 10);
      for (int k = 0; k < 16; k++) begin
         p_hit[k]  = ($urandom_range(0, 3) != 0);
         p_ncol[k] = rnd72() | {3{24'h010000}};
         if ($urandom_range(0, 5) == 0) p_ncol[k] = p_ncol[k] & ~EXP_MASK;
         p_nlit[k] = rnd72(); p_ndir[k] = rnd72(); p_norg[k] = rnd72();
         p_pos[k]  = rnd72(); p_nrm[k]  = rnd72();
         m = {$urandom(), $urandom()};
         p_mat[k]  = m[55:0];
         p_rlat[k] = $urandom_range(0, 8);
      end
   endtask

   // Reference: walk the bounce list and stop at a miss, stall, the cap, or a black colour.
   task automatic model_path(output int starts, output int pulses, output logic [71:0] col,
                             output logic err);
      logic [71:0] lt;
      lt = '0; starts = 0; pulses = 0; err = 1'b0;
      for (int k = 0; k < 16; k++) begin
         starts++;
         if (!p_hit[k]) break;
         pulses++;
         if (k == p_stall) begin err = 1'b1; break; end
         lt = p_nlit[k];
         if (k + 1 == MAXB || (p_ncol[k] & EXP_MASK) == 72'd0) break;
      end
      col = lt;
   endtask

   task automatic run_path();
      int n, k, s0, q0, es, ep;
      logic [71:0] ec, c0;
      logic ee, fin, aborted, hold_ok;
      n = 0;
      while (!ray_ready && n < 20) begin @(negedge clk); n++; end
      check("idle_ready", ray_ready, 1);
      s0 = n_start; q0 = n_pulse;
      ray_origin = p_ro; ray_dir = p_rd; ray_valid = 1'b1;
      @(negedge clk);
      ray_valid = 1'b0;
      k = 0; fin = 1'b0; aborted = 1'b0;
      while (!fin) begin
         n = 0;
         while (!isect_start && !pix_valid && n < 100) begin @(negedge clk); n++; end
         check("step_latency", n, 0);
         if (pix_valid) fin = 1'b1;
         else if (!isect_start) begin
            check("isect_start_seen", 0, 1); fin = 1'b1; aborted = 1'b1;
         end else begin
            check("isect_origin", isect_origin, (k == 0) ? p_ro : p_norg[k-1]);
            check("isect_dir", isect_dir, (k == 0) ? p_rd : p_ndir[k-1]);
            repeat (1 + p_ilat) @(negedge clk);
            isect_done = 1'b1; isect_hit = p_hit[k];
            isect_pos = p_pos[k]; isect_normal = p_nrm[k]; isect_mat = p_mat[k];
            @(negedge clk);
            isect_done = 1'b0; isect_hit = 1'b0;
            if (p_hit[k]) begin
               check("rflx_hit_valid", rflx_hit_valid, 1);
               check("rflx_ray_color", rflx_ray_color, (k == 0) ? ONE3 : p_ncol[k-1]);
               check("rflx_income_light", rflx_income_light, (k == 0) ? 72'd0 : p_nlit[k-1]);
               check("rflx_ray_dir", rflx_ray_dir, (k == 0) ? p_rd : p_ndir[k-1]);
               check("rflx_hit_pos", rflx_hit_pos, p_pos[k]);
               check("rflx_hit_normal", rflx_hit_normal, p_nrm[k]);
               check("rflx_hit_mat", rflx_hit_mat, p_mat[k]);
               if (k == p_reset) begin
                  repeat (3) @(negedge clk);
                  #2 rst_n = 1'b0;
                  #1;
                  check("rst_mid_ray_ready", ray_ready, 1);
                  check("rst_mid_pix_valid", pix_valid, 0);
                  check("rst_mid_pix_err", pix_err, 0);
                  check("rst_mid_rflx_hit_valid", rflx_hit_valid, 0);
                  check("rst_mid_rflx_color", rflx_ray_color, 0);
                  check("rst_mid_isect_origin", isect_origin, 0);
                  check("rst_mid_pix_color", pix_color, 0);
                  @(negedge clk);
                  rst_n = 1'b1;
                  repeat (5) @(negedge clk);
                  check("rst_mid_no_pix", pix_valid, 0);
                  return;
               end
               if (k == p_stall) begin
                  n = 0;
                  while (!pix_valid && n < 200) begin @(negedge clk); n++; end
                  check("timeout_latency", n, TMO + 1);
               end else begin
                  repeat (1 + p_rlat[k]) @(negedge clk);
                  check("rflx_hold", rflx_ray_color, (k == 0) ? ONE3 : p_ncol[k-1]);
                  rflx_done = 1'b1;
                  rflx_new_dir = p_ndir[k]; rflx_new_origin = p_norg[k];
                  rflx_new_color = p_ncol[k]; rflx_new_income_light = p_nlit[k];
                  @(negedge clk);
                  rflx_done = 1'b0;
               end
            end
            k++;
         end
      end
      if (aborted) return;
      model_path(es, ep, ec, ee);
      check("pix_valid", pix_valid, 1);
      check("pix_color", pix_color, ec);
      check("pix_err", pix_err, ee);
      check("isect_start_count", n_start - s0, es);
      check("rflx_pulse_count", n_pulse - q0, ep);
      check("ray_ready_busy", ray_ready, 0);
      hold_ok = 1'b1; c0 = pix_color;
      for (int i = 0; i < p_hold; i++) begin
         @(negedge clk);
         if (pix_color !== c0 || pix_valid !== 1'b1 || ray_ready !== 1'b0 || pix_err !== ee)
            hold_ok = 1'b0;
      end
      check("hold_stable", hold_ok, 1);
      pix_ready = 1'b1;
      @(negedge clk);
      pix_ready = 1'b0;
      check("ray_ready_after", ray_ready, 1);
      check("pix_valid_clear", pix_valid, 0);
      check("pix_err_clear", pix_err, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ray_ready", ray_ready, 1);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_isect_start", isect_start, 0);
      check("rst_rflx_hit_valid", rflx_hit_valid, 0);
      check("rst_isect_origin", isect_origin, 0);
      check("rst_pix_color", pix_color, 0);
      rst_n = 1'b1;
      @(negedge clk);

      gen_path(); p_hit[0] = 1'b0; p_ilat = 2; run_path();

      gen_path(); p_hit[0] = 1'b1; p_hit[1] = 1'b0;
      p_nlit[0] = ONE3; p_ncol[0] = ONE3; run_path();

      gen_path();
      for (int k = 0; k < 16; k++) begin
         p_hit[k] = 1'b1; p_ncol[k] = p_ncol[k] | {3{24'h010000}};
      end
      run_path();

      gen_path(); p_hit[0] = 1'b1; p_hit[1] = 1'b1; p_ncol[0] = '0; run_path();

      gen_path(); p_hit[0] = 1'b1; p_hit[1] = 1'b1;
      p_ncol[0] = {24'h00ABCD, 24'h001234, 24'h80FFFF}; run_path();

      gen_path(); p_hit[0] = 1'b1; p_hit[1] = 1'b0;
      p_ncol[0] = {24'h000001, 24'h010000, 24'h000000}; run_path();

      gen_path(); p_hit[0] = 1'b1; p_hit[1] = 1'b1;
      p_ncol[0] = ONE3; p_stall = 1; run_path();

      @(negedge clk);
      rflx_done = 1'b1; rflx_new_color = '0; rflx_new_income_light = rnd72();
      @(negedge clk);
      rflx_done = 1'b0;
      repeat (2) @(negedge clk);
      check("stray_ray_ready", ray_ready, 1);
      check("stray_pix_valid", pix_valid, 0);
      check("stray_isect_start", isect_start, 0);
      check("stray_rflx_hit_valid", rflx_hit_valid, 0);
      gen_path(); p_hit[0] = 1'b1; p_hit[1] = 1'b0; p_ncol[0] = ONE3; run_path();

      gen_path(); p_hit[0] = 1'b1; p_hit[1] = 1'b0;
      p_ncol[0] = ONE3; p_rlat[0] = TMO - 1; run_path();

      gen_path(); p_hit[0] = 1'b1; p_hit[1] = 1'b0; p_hold = 10; run_path();

      gen_path(); p_hit[0] = 1'b1; p_reset = 0; run_path();

      repeat (40) begin
         gen_path();
         if ($urandom_range(0, 7) == 0) p_stall = $urandom_range(0, 3);
         run_path();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
